// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner
//
// Multiplexed driver for a common-anode seven-segment bank. One digit is
// driven per slot of TICK_CYCLES clocks. Within a slot the digit is lit for
// (brightness+1)*TICK_CYCLES/2**BRIGHT_W cycles and dark for the rest.
// Display data is copied into shadow registers when the scan wraps to digit 0,
// so a whole frame always shows one consistent snapshot.
//
// Optional build macro:
//   SEVSEG_LZ_BLANK_EN - leading-zero suppression, evaluated on the data being
//                        latched at the start of each frame.
//
// Ports:
//   clk          system clock
//   reset_n      synchronous active-low reset
//   dig          hex value per digit, index 0 = rightmost
//   dp_in        decimal point request per digit, active-high
//   blank        force digit dark, active-high
//   brightness   duty code, sampled at each slot boundary
//   seg          segments a..g on seg[0]..seg[6], active-low
//   dp           decimal point, active-low
//   an           anodes, active-low, at most one low
//   frame_start  one-cycle pulse when a new frame's data is latched
module seven_segment_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int TICK_CYCLES = 200_000,
  parameter int BRIGHT_W    = 3
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_DIGITS-1:0][3:0] dig,
  input  logic [NUM_DIGITS-1:0]      dp_in,
  input  logic [NUM_DIGITS-1:0]      blank,
  input  logic [BRIGHT_W-1:0]        brightness,
  output logic [6:0]                 seg,
  output logic                       dp,
  output logic [NUM_DIGITS-1:0]      an,
  output logic                       frame_start
);

  // Counter width holds TICK_CYCLES itself, so on_cnt can express "lit for
  // the whole slot" and cnt+1 compares against it without overflow.
  localparam int CW   = $clog2(TICK_CYCLES + 1);
  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int STEP = TICK_CYCLES >> BRIGHT_W;

  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_CYCLES - 1);
  localparam logic [CW-1:0] STEP_V   = CW'(STEP);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  logic [CW-1:0]                cnt;
  logic [CW-1:0]                on_cnt;
  logic [IW-1:0]                digit_idx;
  logic [NUM_DIGITS-1:0][3:0]   sh_dig;
  logic [NUM_DIGITS-1:0]        sh_dp;
  logic [NUM_DIGITS-1:0]        sh_blank;

  logic                         boundary;
  logic                         wrap;
  logic [CW-1:0]                cnt_inc;
  logic [CW-1:0]                on_cnt_new;
  logic [IW-1:0]                next_idx;
  logic [NUM_DIGITS-1:0]        lz_mask;
  logic [NUM_DIGITS-1:0][3:0]   sh_dig_n;
  logic [NUM_DIGITS-1:0]        sh_dp_n;
  logic [NUM_DIGITS-1:0]        sh_blank_n;
  logic [NUM_DIGITS-1:0]        an_n;
  logic [6:0]                   seg_n;
  logic                         dp_n;

  assign boundary   = (cnt == CNT_LAST);
  assign wrap       = boundary && (digit_idx == IDX_LAST);
  assign cnt_inc    = cnt + CW'(1);
  assign on_cnt_new = (CW'(brightness) + CW'(1)) * STEP_V;
  assign next_idx   = (digit_idx == IDX_LAST) ? '0 : digit_idx + IW'(1);

  // Leading-zero mask over the data about to be latched. Scans from the
  // leftmost digit down to digit 1; digit 0 is never suppressed.
`ifdef SEVSEG_LZ_BLANK_EN
  always_comb begin
    logic run;
    lz_mask = '0;
    run     = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (run && (dig[i] == 4'h0) && !dp_in[i]) begin
        lz_mask[i] = 1'b1;
      end else begin
        run = 1'b0;
      end
    end
  end
`else
  assign lz_mask = '0;
`endif

  // Shadow contents as they will be after this edge; the first digit of a
  // frame is drawn from the freshly latched data on the same edge.
  always_comb begin
    sh_dig_n   = sh_dig;
    sh_dp_n    = sh_dp;
    sh_blank_n = sh_blank;
    if (wrap) begin
      sh_dig_n   = dig;
      sh_dp_n    = dp_in;
      sh_blank_n = blank | lz_mask;
    end
  end

  // Output pattern for the digit that starts at the coming boundary.
  always_comb begin
    an_n  = '1;
    seg_n = 7'b1111111;
    dp_n  = 1'b1;
    if (!sh_blank_n[next_idx]) begin
      an_n  = ~(NUM_DIGITS'(1) << next_idx);
      seg_n = glyph(sh_dig_n[next_idx]);
      dp_n  = ~sh_dp_n[next_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt         <= '0;
      on_cnt      <= '0;
      digit_idx   <= IDX_LAST;
      sh_dig      <= '0;
      sh_dp       <= '0;
      sh_blank    <= '0;
      an          <= '1;
      seg         <= 7'b1111111;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      sh_dig      <= sh_dig_n;
      sh_dp       <= sh_dp_n;
      sh_blank    <= sh_blank_n;
      frame_start <= wrap;
      if (boundary) begin
        cnt       <= '0;
        digit_idx <= next_idx;
        on_cnt    <= on_cnt_new;
        an        <= an_n;
        seg       <= seg_n;
        dp        <= dp_n;
      end else begin
        cnt <= cnt_inc;
        // Lit period ends on the edge where cnt reaches on_cnt. With
        // on_cnt == TICK_CYCLES this never fires, so slots abut.
        if (cnt_inc == on_cnt) begin
          an  <= '1;
          seg <= 7'b1111111;
          dp  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
module tb_seven_segment_scanner;

  localparam int N    = 4;
  localparam int TICK = 16;
  localparam int BW   = 2;
  localparam int W    = 18;  // {an[3:0], seg[6:0], dp, lit_cycles[4:0], frame_start}

`ifdef SEVSEG_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic              clk;
  logic              reset_n;
  logic [N-1:0][3:0] dig;
  logic [N-1:0]      dp_in;
  logic [N-1:0]      blank;
  logic [BW-1:0]     brightness;
  logic [6:0]        seg;
  logic              dp;
  logic [N-1:0]      an;
  logic              frame_start;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];

  seven_segment_scanner #(
    .NUM_DIGITS (N),
    .TICK_CYCLES(TICK),
    .BRIGHT_W   (BW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .dig        (dig),
    .dp_in      (dp_in),
    .blank      (blank),
    .brightness (brightness),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_start(frame_start)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- common check ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_exp(input logic [3:0] a, input logic [6:0] s, input logic d,
                          input int lit, input logic fs);
    exp_q.push_back({a, s, d, 5'(lit), fs});
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset();
    chk("reset_an", 32'(an), 32'hF);
    chk("reset_seg", 32'(seg), 32'h7F);
    chk("reset_dp", 32'(dp), 32'h1);
    chk("reset_frame_start", 32'(frame_start), 32'h0);
  endtask

  // Leading-zero-dependent slot: dark when suppression is built in.
  task automatic lz_slot(input logic [3:0] a);
    if (LZ) push_exp(4'hF, 7'h7F, 1'b1, 0, 1'b0);
    else    push_exp(a, 7'b1000000, 1'b1, 16, 1'b0);
    cycles(16);
  endtask

  // ---------------- monitor / scoreboard ----------------
  int           mon_cyc = 0;
  int           lit_cnt;
  logic [11:0]  lit_val;
  logic         fs_seen, fs_extra, noncontig, changed, dark_bad, hot_bad;
  logic [W-1:0] e;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        mon_cyc = 0;
      end else begin
        if (mon_cyc == 0) begin
          lit_cnt   = 0;
          lit_val   = {4'hF, 7'h7F, 1'b1};
          fs_seen   = frame_start;
          fs_extra  = 1'b0;
          noncontig = 1'b0;
          changed   = 1'b0;
          dark_bad  = 1'b0;
          hot_bad   = 1'b0;
        end else if (frame_start) begin
          fs_extra = 1'b1;
        end
        if (an != 4'hF) begin
          if ($countones(~an) != 1) hot_bad = 1'b1;
          if (lit_cnt != mon_cyc) noncontig = 1'b1;
          if (lit_cnt == 0) lit_val = {an, seg, dp};
          else if ({an, seg, dp} != lit_val) changed = 1'b1;
          lit_cnt++;
        end else if (seg != 7'h7F || dp != 1'b1) begin
          dark_bad = 1'b1;
        end
        if (mon_cyc == TICK - 1) begin
          if (exp_q.size() == 0) begin
            chk("queue_empty", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("slot_an_seg_dp", 32'(lit_val), 32'(e[17:6]));
            chk("slot_lit_cycles", 32'(lit_cnt), 32'(e[5:1]));
            chk("slot_frame_start", 32'(fs_seen), 32'(e[0]));
            chk("slot_shape", 32'({fs_extra, noncontig, changed, dark_bad, hot_bad}), 32'h0);
          end
          mon_cyc = 0;
        end else begin
          mon_cyc++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset_n    = 1'b0;
    dig        = {4'hF, 4'h8, 4'h1, 4'h0};
    dp_in      = '0;
    blank      = '0;
    brightness = 2'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset();
    @(posedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);

    // First slot dark, then full-brightness frame with abutting slots.
    push_exp(4'hF, 7'h7F, 1'b1, 0, 1'b0);         cycles(16);
    push_exp(4'hE, 7'b1000000, 1'b1, 16, 1'b1);   cycles(16);
    push_exp(4'hD, 7'b1111001, 1'b1, 16, 1'b0);   cycles(16);
    push_exp(4'hB, 7'b0000000, 1'b1, 16, 1'b0);   cycles(16);
    push_exp(4'h7, 7'b0001110, 1'b1, 16, 1'b0);
    brightness = 2'd0;                             cycles(16);

    // Minimum brightness; mid-slot brightness and data changes are deferred.
    push_exp(4'hE, 7'b1000000, 1'b1, 4, 1'b1);    cycles(16);
    push_exp(4'hD, 7'b1111001, 1'b1, 4, 1'b0);    cycles(2);
    dig[2]     = 4'h7;
    brightness = 2'd1;                             cycles(14);
    push_exp(4'hB, 7'b0000000, 1'b1, 8, 1'b0);    cycles(16);
    push_exp(4'h7, 7'b0001110, 1'b1, 8, 1'b0);
    brightness = 2'd3;                             cycles(16);

    // New frame shows the 7; blank/dp set now apply from the following frame.
    push_exp(4'hE, 7'b1000000, 1'b1, 16, 1'b1);
    blank = 4'b0100;
    dp_in = 4'b0001;                               cycles(16);
    push_exp(4'hD, 7'b1111001, 1'b1, 16, 1'b0);   cycles(16);
    push_exp(4'hB, 7'b1111000, 1'b1, 16, 1'b0);   cycles(16);
    push_exp(4'h7, 7'b0001110, 1'b1, 16, 1'b0);   cycles(16);

    // Blanked digit 2, decimal point on digit 0.
    push_exp(4'hE, 7'b1000000, 1'b0, 16, 1'b1);
    blank = '0;
    dp_in = '0;
    dig   = {4'h0, 4'h0, 4'h5, 4'h0};             cycles(16);
    push_exp(4'hD, 7'b1111001, 1'b1, 16, 1'b0);   cycles(16);
    push_exp(4'hF, 7'h7F, 1'b1, 0, 1'b0);         cycles(16);
    push_exp(4'h7, 7'b0001110, 1'b1, 16, 1'b0);   cycles(16);

    // dig = 0050
    push_exp(4'hE, 7'b1000000, 1'b1, 16, 1'b1);
    dig = '0;                                      cycles(16);
    push_exp(4'hD, 7'b0010010, 1'b1, 16, 1'b0);   cycles(16);
    lz_slot(4'hB);
    lz_slot(4'h7);

    // dig = 0000
    push_exp(4'hE, 7'b1000000, 1'b1, 16, 1'b1);   cycles(16);
    lz_slot(4'hD);
    lz_slot(4'hB);
    lz_slot(4'h7);

    // Reset in the middle of a slot aborts everything.
    cycles(5);
    @(posedge clk);
    #2 reset_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check_reset();
    @(posedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    push_exp(4'hF, 7'h7F, 1'b1, 0, 1'b0);         cycles(16);
    push_exp(4'hE, 7'b1000000, 1'b1, 16, 1'b1);   cycles(16);
    cycles(2);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
